// File: rtl/msrv32_pipe_ctrl_pkg.sv
// Shared types for the msrv32 pipeline sequencer: state encodings and the
// packed enable/flush control bundle driven to the PC and pipeline registers.
package msrv32_pipe_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PC_BOOT     = 3'd0,
        PC_RUN      = 3'd1,
        PC_MEM_WAIT = 3'd2,
        PC_FLUSH    = 3'd3,
        PC_ERR      = 3'd4
    } pc_state_e;

    typedef struct packed {
        logic pc_en;
        logic rb1_en;
        logic rb2_en;
        logic rb1_flush;
        logic rb2_flush;
    } pipe_ctl_t;

    // Canned control patterns: freeze, normal advance, redirect (flush both
    // stages), trailing flush of IF/ID, and a single load-use bubble.
    localparam pipe_ctl_t CTL_HOLD     = 5'b00000;
    localparam pipe_ctl_t CTL_RUN      = 5'b11100;
    localparam pipe_ctl_t CTL_REDIRECT = 5'b11111;
    localparam pipe_ctl_t CTL_FLUSH    = 5'b11110;
    localparam pipe_ctl_t CTL_BUBBLE   = 5'b00101;

endpackage

// File: rtl/msrv32_pipe_ctrl_if.sv
// Status/control bundle between the pipeline sequencer (master) and the
// PC / reg_block_1 / reg_block_2 datapath (slave).
interface msrv32_pipe_ctrl_if #(
    parameter int STALL_CNT_W = 16
) ();
    import msrv32_pipe_ctrl_pkg::*;

    // Memory handshake: dmem_req_in stays high while the reg_block_2 access is
    // outstanding; dmem_ack_in completes it in the cycle it is high.
    logic                   branch_taken_in;
    logic                   trap_taken_in;
    logic                   load_hazard_in;
    logic                   dmem_req_in;
    logic                   dmem_ack_in;
    logic                   pc_en_out;
    logic                   rb1_en_out;
    logic                   rb2_en_out;
    logic                   rb1_flush_out;
    logic                   rb2_flush_out;
    logic                   bus_err_out;
    logic [STATE_W-1:0]     state_out;
    logic [STALL_CNT_W-1:0] stall_cnt_out;

    modport master (
        input  branch_taken_in, trap_taken_in, load_hazard_in,
               dmem_req_in, dmem_ack_in,
        output pc_en_out, rb1_en_out, rb2_en_out, rb1_flush_out, rb2_flush_out,
               bus_err_out, state_out, stall_cnt_out
    );

    modport slave (
        output branch_taken_in, trap_taken_in, load_hazard_in,
               dmem_req_in, dmem_ack_in,
        input  pc_en_out, rb1_en_out, rb2_en_out, rb1_flush_out, rb2_flush_out,
               bus_err_out, state_out, stall_cnt_out
    );

endinterface

// File: rtl/msrv32_wait_timer.sv
// Up-counter with synchronous clear and enable; tc flags count == TC.
// Clear and enable together restart the count at one.
module msrv32_wait_timer #(
    parameter int W  = 8,
    parameter int TC = 0
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [W-1:0] TC_V = W'(TC);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cnt <= '0;
        end else if (clr || en) begin
            cnt <= (clr ? '0 : cnt) + W'(en);
        end
    end

    assign tc = (cnt == TC_V);

endmodule

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencer: per-cycle enable/flush controls for the PC and the two
// pipeline register blocks, covering boot, redirects, load-use and memory waits.
module msrv32_pipe_ctrl
    import msrv32_pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 256,
    parameter int STALL_CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    msrv32_pipe_ctrl_if.master pif
);
    localparam int        WAIT_W      = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam int        FLUSH_TC    = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam bit        TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam pc_state_e AFTER_REDIR = (FLUSH_CYCLES > 0) ? PC_FLUSH : PC_RUN;

    pc_state_e              state;
    pc_state_e              state_nxt;
    pipe_ctl_t              ctl;
    logic                   bus_err;
    logic                   bus_err_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   redirect;
    logic                   mem_stall;
    logic                   boot_tc;
    logic                   flush_tc;
    logic                   wait_tc;
    logic                   stall_inc;

    assign redirect  = pif.branch_taken_in || pif.trap_taken_in;
    assign mem_stall = pif.dmem_req_in && !pif.dmem_ack_in;

    msrv32_wait_timer #(.W(8), .TC(BOOT_CYCLES - 1)) u_boot_timer (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (state != PC_BOOT),
        .en       (state == PC_BOOT),
        .tc       (boot_tc)
    );

    // A redirect inside FLUSH restarts the trailing-flush window from zero.
    msrv32_wait_timer #(.W(3), .TC(FLUSH_TC)) u_flush_timer (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      ((state != PC_FLUSH) || redirect),
        .en       ((state == PC_FLUSH) && !redirect),
        .tc       (flush_tc)
    );

    // Loaded with one on the RUN cycle that enters MEM_WAIT.
    msrv32_wait_timer #(.W(WAIT_W), .TC(MEM_TIMEOUT)) u_wait_timer (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (state != PC_MEM_WAIT),
        .en       ((state == PC_MEM_WAIT) || (state == PC_RUN && !redirect && mem_stall)),
        .tc       (wait_tc)
    );

    always_comb begin
        ctl         = CTL_HOLD;
        state_nxt   = state;
        bus_err_nxt = bus_err;
        case (state)
            PC_BOOT: begin
                if (boot_tc) state_nxt = PC_RUN;
            end
            PC_RUN: begin
                if (redirect) begin
                    ctl       = CTL_REDIRECT;
                    state_nxt = AFTER_REDIR;
                end else if (mem_stall) begin
                    state_nxt = PC_MEM_WAIT;
                end else if (pif.dmem_req_in) begin
                    ctl = CTL_RUN;
                end else if (pif.load_hazard_in) begin
                    ctl = CTL_BUBBLE;
                end else begin
                    ctl = CTL_RUN;
                end
            end
            PC_FLUSH: begin
                if (redirect) begin
                    ctl = CTL_REDIRECT;
                end else begin
                    ctl = CTL_FLUSH;
                    if (flush_tc) state_nxt = PC_RUN;
                end
            end
            PC_MEM_WAIT: begin
                // Ack beats a coincident timeout.
                if (pif.dmem_ack_in) begin
                    ctl       = CTL_RUN;
                    state_nxt = PC_RUN;
                end else if (TIMEOUT_EN && wait_tc) begin
                    state_nxt   = PC_ERR;
                    bus_err_nxt = 1'b1;
                end
            end
            PC_ERR: begin
                if (pif.trap_taken_in) begin
                    ctl         = CTL_REDIRECT;
                    bus_err_nxt = 1'b0;
                    state_nxt   = AFTER_REDIR;
                end
            end
            default: begin
                state_nxt = PC_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state   <= PC_BOOT;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= bus_err_nxt;
        end
    end

    assign stall_inc = ((state == PC_RUN) || (state == PC_MEM_WAIT) || (state == PC_ERR))
                       && !ctl.pc_en;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign pif.pc_en_out     = ctl.pc_en;
    assign pif.rb1_en_out    = ctl.rb1_en;
    assign pif.rb2_en_out    = ctl.rb2_en;
    assign pif.rb1_flush_out = ctl.rb1_flush;
    assign pif.rb2_flush_out = ctl.rb2_flush;
    assign pif.bus_err_out   = bus_err;
    assign pif.state_out     = state;
    assign pif.stall_cnt_out = stall_cnt;

endmodule
